// File: rtl/shl_pipe8.sv
// 8-bit left shifter/rotator built from three registered stages: shift by 1, 2 and 4.
// Latency: 3 rising edges from the accepting edge to out_valid. Sustains 1 op/clock.
// Backpressure: combinational ready chain from out_ready to in_ready; each stage holds while its ready is low.
module shl_pipe8 #(
    parameter int WIDTH = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] in_data,
    input  logic [2:0]       in_amt,
    input  logic             in_rot,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] out_data,
    output logic             out_carry
);

    // One stage step: returns {carry, data}. With en=0 data and carry pass through.
    // The carry is the last bit pushed past the MSB, d[8-sh], which is bit 8 of the
    // zero-extended operand after the shift.
    function automatic logic [WIDTH:0] stage_step(
        input logic [WIDTH-1:0] d,
        input logic             c,
        input logic             rot,
        input logic             en,
        input logic [2:0]       sh
    );
        logic [WIDTH:0]     ext;
        logic [2*WIDTH-1:0] rw;
        ext = {1'b0, d} << sh;
        rw  = {d, d} << sh;
        if (!en)
            return {c, d};
        return {ext[WIDTH], rot ? rw[2*WIDTH-1:WIDTH] : ext[WIDTH-1:0]};
    endfunction

    // Stage 1: shift-by-1 result plus the amount bits still to apply
    logic             v1, c1, r1;
    logic [WIDTH-1:0] d1;
    logic [1:0]       a1;
    // Stage 2: shift-by-2 result
    logic             v2, c2, r2, a2;
    logic [WIDTH-1:0] d2;
    // Stage 3: shift-by-4 result, drives the outputs directly
    logic             v3, c3;
    logic [WIDTH-1:0] d3;

    logic rdy1, rdy2, rdy3;

    // Ready chain: a stage can load when it is empty or the stage after it can load
    always_comb begin
        rdy3 = !v3 || out_ready;
        rdy2 = !v2 || rdy3;
        rdy1 = !v1 || rdy2;
    end

    assign in_ready  = rdy1;
    assign out_valid = v3;
    assign out_data  = d3;
    assign out_carry = c3;

    // Stage 1 register: captures the operand; carry starts at 0 when no shift-by-1
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v1 <= 1'b0;
            c1 <= 1'b0;
            r1 <= 1'b0;
            d1 <= '0;
            a1 <= '0;
        end else if (rdy1) begin
            v1         <= in_valid;
            {c1, d1}   <= stage_step(in_data, 1'b0, in_rot, in_amt[0], 3'd1);
            r1         <= in_rot;
            a1         <= in_amt[2:1];
        end
    end

    // Stage 2 register: applies shift-by-2; a bubble from stage 1 clears v2
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v2 <= 1'b0;
            c2 <= 1'b0;
            r2 <= 1'b0;
            d2 <= '0;
            a2 <= 1'b0;
        end else if (rdy2) begin
            v2         <= v1;
            {c2, d2}   <= stage_step(d1, c1, r1, a1[0], 3'd2);
            r2         <= r1;
            a2         <= a1[1];
        end
    end

    // Stage 3 register: applies shift-by-4; holds steady while downstream stalls
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            v3 <= 1'b0;
            c3 <= 1'b0;
            d3 <= '0;
        end else if (rdy3) begin
            v3         <= v2;
            {c3, d3}   <= stage_step(d2, c2, r2, a2, 3'd4);
        end
    end

endmodule

// File: tb/tb_shl_pipe8.sv
// Self-checking bench for shl_pipe8: directed vectors, streaming, backpressure,
// asynchronous reset mid-stream, then a randomized run against a reference model.
// Inputs change on the falling edge; outputs are sampled 1 time unit later.
module tb_shl_pipe8;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       in_valid, in_ready, in_rot;
    logic [7:0] in_data;
    logic [2:0] in_amt;
    logic       out_valid, out_ready, out_carry;
    logic [7:0] out_data;

    int checks   = 0;
    int failures = 0;
    logic [8:0] q[$];

    shl_pipe8 #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .in_data   (in_data),
        .in_amt    (in_amt),
        .in_rot    (in_rot),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .out_data  (out_data),
        .out_carry (out_carry)
    );

    always #5 clk = ~clk;

    // Reference: whole shift done at once with multiplication/division.
    function automatic logic [8:0] model(input logic [7:0] d, input int amt, input logic rot);
        int v, r, c;
        v = int'(d) * (1 << amt);
        r = v % 256;
        c = 0;
        if (amt != 0) begin
            c = (int'(d) >> (8 - amt)) % 2;
            if (rot) r = r + (int'(d) >> (8 - amt));
        end
        return {c[0], r[7:0]};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic drive(input logic v, input logic [7:0] d, input logic [2:0] a, input logic r);
        in_valid = v;
        in_data  = d;
        in_amt   = a;
        in_rot   = r;
    endtask

    task automatic next_cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    // One op on an idle pipe: checks ready, 3-edge latency and the result.
    task automatic run_one(input logic [7:0] d, input logic [2:0] a, input logic r,
                           input logic [7:0] exp_d, input logic exp_c);
        out_ready = 1'b1;
        drive(1'b1, d, a, r);
        #1 chk("one_in_ready", 32'(in_ready), 32'd1);
        next_cycle();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        #1 chk("one_lat_edge1", 32'(out_valid), 32'd0);
        next_cycle();
        #1 chk("one_lat_edge2", 32'(out_valid), 32'd0);
        next_cycle();
        #1;
        chk("one_valid", 32'(out_valid), 32'd1);
        chk("one_data", 32'(out_data), 32'(exp_d));
        chk("one_carry", 32'(out_carry), 32'(exp_c));
        next_cycle();
    endtask

    // Random-phase cycle: scoreboard check of emitted results, occupancy-based ready check.
    task automatic tick();
        logic [8:0] e;
        #1;
        chk("rnd_in_ready", 32'(in_ready), 32'((q.size() < 3) || out_ready));
        if (out_valid && out_ready) begin
            chk("rnd_out_has_pending", 32'(q.size() != 0), 32'd1);
            if (q.size() != 0) begin
                e = q.pop_front();
                chk("rnd_data", 32'(out_data), 32'(e[7:0]));
                chk("rnd_carry", 32'(out_carry), 32'(e[8]));
            end
        end
        if (in_valid && in_ready)
            q.push_back(model(in_data, int'(in_amt), in_rot));
        next_cycle();
    endtask

    initial begin
        logic [7:0] bp_d[4];
        logic [2:0] bp_a[4];
        logic       bp_r[4];
        logic [8:0] e;

        rst_n     = 1'b1;
        out_ready = 1'b1;
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        #1 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 32'd0);
        chk("rst_out_data", 32'(out_data), 32'd0);
        chk("rst_out_carry", 32'(out_carry), 32'd0);
        chk("rst_in_ready", 32'(in_ready), 32'd1);
        @(negedge clk);
        next_cycle();
        rst_n = 1'b1;
        #1 chk("idle_out_valid", 32'(out_valid), 32'd0);

        // Directed single ops
        @(negedge clk);
        run_one(8'hB3, 3'd3, 1'b0, 8'h98, 1'b1);
        run_one(8'hB3, 3'd3, 1'b1, 8'h9D, 1'b1);
        run_one(8'hFF, 3'd7, 1'b0, 8'h80, 1'b1);
        run_one(8'h01, 3'd7, 1'b0, 8'h80, 1'b0);
        run_one(8'hB3, 3'd0, 1'b1, 8'hB3, 1'b0);
        run_one(8'h80, 3'd1, 1'b1, 8'h01, 1'b1);

        // Back-to-back stream: 0x01 shifted by 0..7, one per cycle
        out_ready = 1'b1;
        for (int cyc = 0; cyc <= 10; cyc++) begin
            if (cyc < 8) drive(1'b1, 8'h01, 3'(cyc), 1'b0);
            else         drive(1'b0, 8'h00, 3'd0, 1'b0);
            #1;
            if (cyc < 8) chk("b2b_in_ready", 32'(in_ready), 32'd1);
            if (cyc >= 3) begin
                chk("b2b_valid", 32'(out_valid), 32'd1);
                chk("b2b_data", 32'(out_data), 32'(1 << (cyc - 3)));
            end else begin
                chk("b2b_empty", 32'(out_valid), 32'd0);
            end
            next_cycle();
        end
        #1 chk("b2b_done", 32'(out_valid), 32'd0);

        // Backpressure: 3 ops fill the pipe, the 4th waits until out_ready rises
        bp_d = '{8'h5A, 8'hC3, 8'h81, 8'h3C};
        bp_a = '{3'd1, 3'd6, 3'd2, 3'd5};
        bp_r = '{1'b0, 1'b1, 1'b1, 1'b0};
        @(negedge clk);
        out_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            drive(1'b1, bp_d[i], bp_a[i], bp_r[i]);
            #1 chk("bp_fill_ready", 32'(in_ready), 32'd1);
            next_cycle();
        end
        drive(1'b1, bp_d[3], bp_a[3], bp_r[3]);
        e = model(bp_d[0], int'(bp_a[0]), bp_r[0]);
        for (int i = 0; i < 3; i++) begin
            #1;
            chk("bp_full_ready", 32'(in_ready), 32'd0);
            chk("bp_hold_valid", 32'(out_valid), 32'd1);
            chk("bp_hold_data", 32'({out_carry, out_data}), 32'(e));
            next_cycle();
        end
        out_ready = 1'b1;
        #1 chk("bp_release_ready", 32'(in_ready), 32'd1);
        next_cycle();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        for (int i = 1; i < 4; i++) begin
            e = model(bp_d[i], int'(bp_a[i]), bp_r[i]);
            #1;
            chk("bp_order_valid", 32'(out_valid), 32'd1);
            chk("bp_order_data", 32'({out_carry, out_data}), 32'(e));
            next_cycle();
        end
        #1 chk("bp_drained", 32'(out_valid), 32'd0);

        // Asynchronous reset with two ops in flight
        @(negedge clk);
        drive(1'b1, 8'hF0, 3'd1, 1'b0);
        next_cycle();
        drive(1'b1, 8'h0F, 3'd2, 1'b1);
        next_cycle();
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        next_cycle();
        #1 chk("arst_pre_valid", 32'(out_valid), 32'd1);
        #1 rst_n = 1'b0;
        #1;
        chk("arst_valid", 32'(out_valid), 32'd0);
        chk("arst_data", 32'(out_data), 32'd0);
        chk("arst_carry", 32'(out_carry), 32'd0);
        next_cycle();
        rst_n = 1'b1;
        for (int i = 0; i < 5; i++) begin
            #1 chk("arst_no_stale", 32'(out_valid), 32'd0);
            next_cycle();
        end
        run_one(8'h6D, 3'd4, 1'b1, 8'hD6, 1'b0);

        // Randomized traffic against the reference model
        for (int i = 0; i < 400; i++) begin
            drive($urandom_range(0, 3) != 0, 8'($urandom), 3'($urandom_range(0, 7)),
                  1'($urandom_range(0, 1)));
            out_ready = ($urandom_range(0, 3) != 0);
            tick();
        end
        drive(1'b0, 8'h00, 3'd0, 1'b0);
        out_ready = 1'b1;
        for (int i = 0; i < 10 && q.size() != 0; i++) tick();
        chk("rnd_drain_empty", 32'(q.size()), 32'd0);
        #1 chk("rnd_final_valid", 32'(out_valid), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
